// File: rtl/wd_ocl_csr.sv
// ============================================================================
//  Module   : wd_ocl_csr
//  Brief    : AXI4-Lite CSR bank on the shell OCL port for the wiredancer CL.
//             Provides ID, scratch, control, status, a 64-bit cycle counter
//             with high-word snapshot, and a completed-write counter.
//  Options  : WD_OCL_SLVERR_EN - unmapped accesses answer SLVERR with rdata 0
//             (otherwise OKAY with rdata 32'hDEAD_BEEF).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module wd_ocl_csr #(
   parameter int unsigned ADDR_W   = 8,
   parameter logic [31:0] ID_VALUE = 32'hF00D_0001,
   parameter int unsigned NUM_CTRL = 8
) (
   input  logic                clk_main_a0,
   input  logic                rst_main_n,
   input  logic [31:0]         sh_ocl_awaddr,
   input  logic                sh_ocl_awvalid,
   output logic                cl_ocl_awready,
   input  logic [31:0]         sh_ocl_wdata,
   input  logic [3:0]          sh_ocl_wstrb,
   input  logic                sh_ocl_wvalid,
   output logic                cl_ocl_wready,
   output logic [1:0]          cl_ocl_bresp,
   output logic                cl_ocl_bvalid,
   input  logic                sh_ocl_bready,
   input  logic [31:0]         sh_ocl_araddr,
   input  logic                sh_ocl_arvalid,
   output logic                cl_ocl_arready,
   output logic [31:0]         cl_ocl_rdata,
   output logic [1:0]          cl_ocl_rresp,
   output logic                cl_ocl_rvalid,
   input  logic                sh_ocl_rready,
   output logic [NUM_CTRL-1:0] ctrl_o,
   input  logic [31:0]         status_i
);

   localparam logic [1:0] RESP_OKAY = 2'b00;

`ifdef WD_OCL_SLVERR_EN
   localparam logic [1:0]  UNMAP_RESP = 2'b10;
   localparam logic [31:0] UNMAP_DATA = 32'h0000_0000;
`else
   localparam logic [1:0]  UNMAP_RESP = RESP_OKAY;
   localparam logic [31:0] UNMAP_DATA = 32'hDEAD_BEEF;
`endif

   // Word indices (byte offset / 4)
   localparam logic [2:0] REG_ID      = 3'd0;
   localparam logic [2:0] REG_SCRATCH = 3'd1;
   localparam logic [2:0] REG_CTRL    = 3'd2;
   localparam logic [2:0] REG_STATUS  = 3'd3;
   localparam logic [2:0] REG_CYC_LO  = 3'd4;
   localparam logic [2:0] REG_CYC_HI  = 3'd5;
   localparam logic [2:0] REG_WR_CNT  = 3'd6;

   localparam logic [0:0] RD_IDLE = 1'b0;
   localparam logic [0:0] RD_RESP = 1'b1;

   // Word address is mapped only when all bits above ADDR_W are zero and
   // it selects one of the seven implemented registers.
   function automatic logic is_mapped(input logic [29:0] wa);
      return ((wa >> (ADDR_W - 2)) == 30'd0) &&
             (wa[29:3] == 27'd0) && (wa[2:0] != 3'd7);
   endfunction

   logic                alive_q,    alive_d;
   logic                aw_held_q,  aw_held_d;
   logic [29:0]         awaddr_q,   awaddr_d;
   logic                w_held_q,   w_held_d;
   logic [31:0]         wdata_q,    wdata_d;
   logic [3:0]          wstrb_q,    wstrb_d;
   logic                bvalid_q,   bvalid_d;
   logic [1:0]          bresp_q,    bresp_d;
   logic [0:0]          rd_state_q, rd_state_d;
   logic [31:0]         rdata_q,    rdata_d;
   logic [1:0]          rresp_q,    rresp_d;
   logic [31:0]         scratch_q,  scratch_d;
   logic [NUM_CTRL-1:0] ctrl_q,     ctrl_d;
   logic [63:0]         cyc_q,      cyc_d;
   logic [31:0]         cyc_hi_q,   cyc_hi_d;
   logic [31:0]         wr_cnt_q,   wr_cnt_d;

   logic [31:0] ctrl_ext;
   logic [31:0] wmask;
   logic [31:0] scratch_merged;
   logic [31:0] ctrl_merged;
   logic [31:0] rd_word;
   logic [29:0] ar_wa;

   // Address bits [1:0] are intentionally ignored by the decoder.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{sh_ocl_awaddr[1:0], sh_ocl_araddr[1:0]};

   assign ar_wa = sh_ocl_araddr[31:2];

   // Byte-lane merge of the held write data and the read mux of current values
   always_comb begin
      ctrl_ext = 32'd0;
      ctrl_ext[NUM_CTRL-1:0] = ctrl_q;
      for (int b = 0; b < 4; b++) begin
         wmask[b*8 +: 8] = {8{wstrb_q[b]}};
      end
      scratch_merged = (scratch_q & ~wmask) | (wdata_q & wmask);
      ctrl_merged    = (ctrl_ext  & ~wmask) | (wdata_q & wmask);
      case (ar_wa[2:0])
         REG_ID:      rd_word = ID_VALUE;
         REG_SCRATCH: rd_word = scratch_q;
         REG_CTRL:    rd_word = ctrl_ext;
         REG_STATUS:  rd_word = status_i;
         REG_CYC_LO:  rd_word = cyc_q[31:0];
         REG_CYC_HI:  rd_word = cyc_hi_q;
         REG_WR_CNT:  rd_word = wr_cnt_q;
         default:     rd_word = UNMAP_DATA;
      endcase
   end

   // Next-state logic for the write channels, read FSM and counters
   always_comb begin
      alive_d    = 1'b1;
      aw_held_d  = aw_held_q;
      awaddr_d   = awaddr_q;
      w_held_d   = w_held_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      scratch_d  = scratch_q;
      ctrl_d     = ctrl_q;
      cyc_d      = cyc_q + 64'd1;
      cyc_hi_d   = cyc_hi_q;
      wr_cnt_d   = wr_cnt_q;

      // Capture AW and W independently; each stays held until the B handshake.
      if (cl_ocl_awready && sh_ocl_awvalid) begin
         aw_held_d = 1'b1;
         awaddr_d  = sh_ocl_awaddr[31:2];
      end
      if (cl_ocl_wready && sh_ocl_wvalid) begin
         w_held_d = 1'b1;
         wdata_d  = sh_ocl_wdata;
         wstrb_d  = sh_ocl_wstrb;
      end

      // Commit one cycle after both halves are held, then raise B.
      if (aw_held_q && w_held_q && !bvalid_q) begin
         bvalid_d = 1'b1;
         if (is_mapped(awaddr_q)) begin
            bresp_d = RESP_OKAY;
            case (awaddr_q[2:0])
               REG_SCRATCH: scratch_d = scratch_merged;
               REG_CTRL:    ctrl_d    = ctrl_merged[NUM_CTRL-1:0];
               default:     ;
            endcase
         end else begin
            bresp_d = UNMAP_RESP;
         end
      end

      // B handshake releases both channels and counts the write.
      if (bvalid_q && sh_ocl_bready) begin
         bvalid_d  = 1'b0;
         bresp_d   = RESP_OKAY;
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         wr_cnt_d  = wr_cnt_q + 32'd1;
      end

      // Read FSM: the mux samples pre-write register values at the AR handshake.
      case (rd_state_q)
         RD_IDLE: begin
            if (alive_q && sh_ocl_arvalid) begin
               rd_state_d = RD_RESP;
               if (is_mapped(ar_wa)) begin
                  rresp_d = RESP_OKAY;
                  rdata_d = rd_word;
                  if (ar_wa[2:0] == REG_CYC_LO) begin
                     cyc_hi_d = cyc_q[63:32];
                  end
               end else begin
                  rresp_d = UNMAP_RESP;
                  rdata_d = UNMAP_DATA;
               end
            end
         end
         RD_RESP: begin
            if (sh_ocl_rready) begin
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // State registers; asynchronous reset discards any pending transaction
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         alive_q    <= 1'b0;
         aw_held_q  <= 1'b0;
         awaddr_q   <= '0;
         w_held_q   <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rd_state_q <= RD_IDLE;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         scratch_q  <= '0;
         ctrl_q     <= '0;
         cyc_q      <= '0;
         cyc_hi_q   <= '0;
         wr_cnt_q   <= '0;
      end else begin
         alive_q    <= alive_d;
         aw_held_q  <= aw_held_d;
         awaddr_q   <= awaddr_d;
         w_held_q   <= w_held_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rd_state_q <= rd_state_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         scratch_q  <= scratch_d;
         ctrl_q     <= ctrl_d;
         cyc_q      <= cyc_d;
         cyc_hi_q   <= cyc_hi_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   // alive_q keeps every ready low until the first clock after reset release.
   assign cl_ocl_awready = alive_q & ~aw_held_q & ~bvalid_q;
   assign cl_ocl_wready  = alive_q & ~w_held_q  & ~bvalid_q;
   assign cl_ocl_bvalid  = bvalid_q;
   assign cl_ocl_bresp   = bresp_q;
   assign cl_ocl_arready = alive_q & (rd_state_q == RD_IDLE);
   assign cl_ocl_rvalid  = (rd_state_q == RD_RESP);
   assign cl_ocl_rdata   = rdata_q;
   assign cl_ocl_rresp   = rresp_q;
   assign ctrl_o         = ctrl_q;

endmodule

`default_nettype wire
